fma_read_buffer: RTL and testbench

FMA_READ_BUFFER -- requirements
Module: fma_read_buffer

---
 rtl/fma_read_buffer.sv | 98 +++++++++
 tb/tb_fma_read_buffer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fma_read_buffer.sv
// Two-entry line FIFO that unpacks each memory line into a/b/c operands for
// FMA_COUNT FMAs and strobes compute_out once per issued line.
module fma_read_buffer #(
    parameter int FMA_COUNT  = 2,
    parameter int WORD_WIDTH = 16,
    parameter int LINE_WIDTH = 3 * WORD_WIDTH * FMA_COUNT
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [LINE_WIDTH-1:0]           line_in,
    input  logic                            line_valid_in,
    output logic                            line_ready_out,
    input  logic                            fma_ready_in,
    output logic [WORD_WIDTH*FMA_COUNT-1:0] a_out,
    output logic [WORD_WIDTH*FMA_COUNT-1:0] b_out,
    output logic [WORD_WIDTH*FMA_COUNT-1:0] c_out,
    output logic                            compute_out,
    output logic [1:0]                      occupancy_out
);
    localparam int OPW = WORD_WIDTH * FMA_COUNT;

    logic [1:0][LINE_WIDTH-1:0] mem;
    logic [LINE_WIDTH-1:0]      head;
    logic                       wr_ptr, rd_ptr;
    logic [1:0]                 count;
    logic                       push, pop;

    assign line_ready_out = (count != 2'd2) && !rst_in;
    assign push           = line_valid_in && line_ready_out;
    // Pop only looks at registered count, so a line never bypasses an empty FIFO
    assign pop            = (count != 2'd0) && fma_ready_in;
    assign head           = mem[rd_ptr];
    assign occupancy_out  = count;

    always_ff @(posedge clk_in) begin
        if (push)
            mem[wr_ptr] <= line_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            compute_out <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            compute_out <= pop;
        end
    end

    for (genvar i = 0; i < FMA_COUNT; i++) begin : g_lane
        fma_read_buffer_lane #(.WORD_WIDTH(WORD_WIDTH)) u_lane (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .load   (pop),
            .a_word (head[0*OPW + i*WORD_WIDTH +: WORD_WIDTH]),
            .b_word (head[1*OPW + i*WORD_WIDTH +: WORD_WIDTH]),
            .c_word (head[2*OPW + i*WORD_WIDTH +: WORD_WIDTH]),
            .a_reg  (a_out[i*WORD_WIDTH +: WORD_WIDTH]),
            .b_reg  (b_out[i*WORD_WIDTH +: WORD_WIDTH]),
            .c_reg  (c_out[i*WORD_WIDTH +: WORD_WIDTH])
        );
    end
endmodule

// Per-FMA operand registers: capture on issue, hold otherwise.
module fma_read_buffer_lane #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  load,
    input  logic [WORD_WIDTH-1:0] a_word,
    input  logic [WORD_WIDTH-1:0] b_word,
    input  logic [WORD_WIDTH-1:0] c_word,
    output logic [WORD_WIDTH-1:0] a_reg,
    output logic [WORD_WIDTH-1:0] b_reg,
    output logic [WORD_WIDTH-1:0] c_reg
);
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            a_reg <= '0;
            b_reg <= '0;
            c_reg <= '0;
        end else if (load) begin
            a_reg <= a_word;
            b_reg <= b_word;
            c_reg <= c_word;
        end
    end
endmodule

// File: tb/tb_fma_read_buffer.sv
// Directed bench for fma_read_buffer: reset, single issue, fill/back-pressure,
// steady stream, reset mid-stream and empty-FIFO hold.
module tb_fma_read_buffer;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [95:0] line_in;
    logic        line_valid_in;
    logic        line_ready_out;
    logic        fma_ready_in;
    logic [31:0] a_out, b_out, c_out;
    logic        compute_out;
    logic [1:0]  occupancy_out;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk_in = ~clk_in;

    fma_read_buffer #(.FMA_COUNT(2), .WORD_WIDTH(16), .LINE_WIDTH(96)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .line_in       (line_in),
        .line_valid_in (line_valid_in),
        .line_ready_out(line_ready_out),
        .fma_ready_in  (fma_ready_in),
        .a_out         (a_out),
        .b_out         (b_out),
        .c_out         (c_out),
        .compute_out   (compute_out),
        .occupancy_out (occupancy_out)
    );

    function automatic logic [95:0] mk_line(input logic [15:0] a0, a1, b0, b1, c0, c1);
        return {c1, c0, b1, b0, a1, a0};
    endfunction

    // Inputs change and outputs are sampled 1ns after the rising edge
    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset;
        rst_in = 1'b1; line_valid_in = 1'b0; fma_ready_in = 1'b0; line_in = '0;
        tick(); tick();
        total++; if (occupancy_out !== 2'd0) $display("FAIL reset_occ got=%0d exp=0", occupancy_out); else pass_cnt++;
        total++; if (compute_out !== 1'b0) $display("FAIL reset_compute got=%0b exp=0", compute_out); else pass_cnt++;
        total++; if ({a_out, b_out, c_out} !== 96'h0) $display("FAIL reset_ops got=%h exp=0", {a_out, b_out, c_out}); else pass_cnt++;
        total++; if (line_ready_out !== 1'b0) $display("FAIL reset_ready_in_rst got=%0b exp=0", line_ready_out); else pass_cnt++;
        rst_in = 1'b0;
        #1;
        total++; if (line_ready_out !== 1'b1) $display("FAIL reset_ready_after got=%0b exp=1", line_ready_out); else pass_cnt++;
    endtask

    task automatic test_single;
        line_in = mk_line(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6);
        line_valid_in = 1'b1; fma_ready_in = 1'b1;
        tick();  // push edge
        line_valid_in = 1'b0;
        total++; if (compute_out !== 1'b0) $display("FAIL single_no_bypass got=%0b exp=0", compute_out); else pass_cnt++;
        total++; if (occupancy_out !== 2'd1) $display("FAIL single_occ1 got=%0d exp=1", occupancy_out); else pass_cnt++;
        tick();  // pop edge
        total++; if (compute_out !== 1'b1) $display("FAIL single_compute got=%0b exp=1", compute_out); else pass_cnt++;
        total++; if (a_out !== 32'h0002_0001) $display("FAIL single_a got=%h exp=00020001", a_out); else pass_cnt++;
        total++; if (b_out !== 32'h0004_0003) $display("FAIL single_b got=%h exp=00040003", b_out); else pass_cnt++;
        total++; if (c_out !== 32'h0006_0005) $display("FAIL single_c got=%h exp=00060005", c_out); else pass_cnt++;
        total++; if (occupancy_out !== 2'd0) $display("FAIL single_occ0 got=%0d exp=0", occupancy_out); else pass_cnt++;
        tick();
        total++; if (compute_out !== 1'b0) $display("FAIL single_one_pulse got=%0b exp=0", compute_out); else pass_cnt++;
        total++; if (a_out !== 32'h0002_0001) $display("FAIL single_hold got=%h exp=00020001", a_out); else pass_cnt++;
    endtask

    task automatic test_fill;
        fma_ready_in = 1'b0; line_valid_in = 1'b1;
        line_in = mk_line(16'h0A00, 16'h0A01, 16'h0B00, 16'h0B01, 16'h0C00, 16'h0C01);
        tick();
        line_in = mk_line(16'h1A00, 16'h1A01, 16'h1B00, 16'h1B01, 16'h1C00, 16'h1C01);
        tick();
        line_in = mk_line(16'h2A00, 16'h2A01, 16'h2B00, 16'h2B01, 16'h2C00, 16'h2C01);
        total++; if (occupancy_out !== 2'd2) $display("FAIL fill_occ2 got=%0d exp=2", occupancy_out); else pass_cnt++;
        total++; if (line_ready_out !== 1'b0) $display("FAIL fill_ready_low got=%0b exp=0", line_ready_out); else pass_cnt++;
        tick();
        total++; if (occupancy_out !== 2'd2) $display("FAIL fill_hold_occ got=%0d exp=2", occupancy_out); else pass_cnt++;
        total++; if (compute_out !== 1'b0) $display("FAIL fill_no_compute got=%0b exp=0", compute_out); else pass_cnt++;
        fma_ready_in = 1'b1;
        tick();  // pop L0, L2 not accepted (full at edge)
        total++; if (compute_out !== 1'b1 || a_out !== 32'h0A01_0A00) $display("FAIL fill_issue0 got=%0b/%h exp=1/0a010a00", compute_out, a_out); else pass_cnt++;
        total++; if (occupancy_out !== 2'd1) $display("FAIL fullpop_occ got=%0d exp=1", occupancy_out); else pass_cnt++;
        total++; if (line_ready_out !== 1'b1) $display("FAIL fullpop_ready got=%0b exp=1", line_ready_out); else pass_cnt++;
        tick();  // push L2, pop L1
        line_valid_in = 1'b0;
        total++; if (compute_out !== 1'b1 || b_out !== 32'h1B01_1B00) $display("FAIL fill_issue1 got=%0b/%h exp=1/1b011b00", compute_out, b_out); else pass_cnt++;
        total++; if (occupancy_out !== 2'd1) $display("FAIL fullpop_push_next got=%0d exp=1", occupancy_out); else pass_cnt++;
        tick();
        total++; if (compute_out !== 1'b1 || c_out !== 32'h2C01_2C00) $display("FAIL fill_issue2 got=%0b/%h exp=1/2c012c00", compute_out, c_out); else pass_cnt++;
        total++; if (occupancy_out !== 2'd0) $display("FAIL fill_drain got=%0d exp=0", occupancy_out); else pass_cnt++;
        tick();
        total++; if (compute_out !== 1'b0) $display("FAIL fill_no_dup got=%0b exp=0", compute_out); else pass_cnt++;
    endtask

    task automatic test_stream;
        logic [15:0] w;
        line_valid_in = 1'b1; fma_ready_in = 1'b1;
        for (int j = 0; j < 10; j++) begin
            w = 16'h0100 + 16'(j);
            line_in = mk_line(w, ~w, w, ~w, w, ~w);
            tick();
            total++;
            if (occupancy_out !== 2'd1) $display("FAIL stream_occ[%0d] got=%0d exp=1", j, occupancy_out); else pass_cnt++;
            total++;
            if (j == 0) begin
                if (compute_out !== 1'b0) $display("FAIL stream_fill[%0d] got=%0b exp=0", j, compute_out); else pass_cnt++;
            end else begin
                w = 16'h0100 + 16'(j - 1);
                if (compute_out !== 1'b1 || a_out !== {~w, w})
                    $display("FAIL stream_issue[%0d] got=%0b/%h exp=1/%h", j, compute_out, a_out, {~w, w});
                else pass_cnt++;
            end
        end
        line_valid_in = 1'b0;
        tick();
        total++; if (compute_out !== 1'b1 || a_out !== 32'hFEF6_0109) $display("FAIL stream_last got=%0b/%h exp=1/fef60109", compute_out, a_out); else pass_cnt++;
        tick();
        total++; if (compute_out !== 1'b0 || occupancy_out !== 2'd0) $display("FAIL stream_end got=%0b/%0d exp=0/0", compute_out, occupancy_out); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        fma_ready_in = 1'b0; line_valid_in = 1'b1;
        line_in = mk_line(16'h5, 16'h6, 16'h7, 16'h8, 16'h9, 16'hA);
        tick(); tick();
        line_valid_in = 1'b0;
        total++; if (occupancy_out !== 2'd2) $display("FAIL rstmid_pre got=%0d exp=2", occupancy_out); else pass_cnt++;
        rst_in = 1'b1;
        tick();
        total++; if (occupancy_out !== 2'd0 || compute_out !== 1'b0) $display("FAIL rstmid_state got=%0d/%0b exp=0/0", occupancy_out, compute_out); else pass_cnt++;
        total++; if ({a_out, b_out, c_out} !== 96'h0) $display("FAIL rstmid_ops got=%h exp=0", {a_out, b_out, c_out}); else pass_cnt++;
        rst_in = 1'b0; fma_ready_in = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            total++; if (compute_out !== 1'b0) $display("FAIL rstmid_no_pulse[%0d] got=%0b exp=0", j, compute_out); else pass_cnt++;
        end
        total++; if (line_ready_out !== 1'b1) $display("FAIL rstmid_ready got=%0b exp=1", line_ready_out); else pass_cnt++;
    endtask

    task automatic test_empty;
        line_in = mk_line(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666);
        line_valid_in = 1'b1; fma_ready_in = 1'b1;
        tick();
        line_valid_in = 1'b0;
        tick();
        total++; if (compute_out !== 1'b1 || a_out !== 32'h2222_1111) $display("FAIL empty_prime got=%0b/%h exp=1/22221111", compute_out, a_out); else pass_cnt++;
        for (int j = 0; j < 3; j++) begin
            tick();
            total++; if (compute_out !== 1'b0) $display("FAIL empty_compute[%0d] got=%0b exp=0", j, compute_out); else pass_cnt++;
            total++;
            if ({a_out, b_out, c_out} !== {32'h2222_1111, 32'h4444_3333, 32'h6666_5555})
                $display("FAIL empty_hold[%0d] got=%h", j, {a_out, b_out, c_out});
            else pass_cnt++;
        end
        total++; if (occupancy_out !== 2'd0) $display("FAIL empty_occ got=%0d exp=0", occupancy_out); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_reset_mid();
        test_empty();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
